// File: rtl/alu_pkg.sv
// Op codes, idle select code and sequencer state encoding shared by the ALU and ac_sequencer.
// Pure declarations: no timing, no flow control.
package alu_pkg;

    localparam logic [3:0] OP_CLAC = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_INAC = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_NOT  = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_LDAC = 4'b1000;

    // ALU output floats and nothing is written while this code is selected
    localparam logic [3:0] ALUS_IDLE = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    function automatic logic op_legal(input logic [3:0] op);
        return (op <= OP_LDAC);
    endfunction

    // LDAC bypasses the ALU, so only the true ALU ops honour the repeat count
    function automatic logic op_uses_alu(input logic [3:0] op);
        return op_legal(op) && (op != OP_LDAC);
    endfunction

endpackage

// File: rtl/rep_counter.sv
// Loadable down-counter for the repeat count; o_last is high while the count is zero.
// Load wins over decrement; decrement saturates at zero so the count never wraps.
module rep_counter #(
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_last
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - ONE;
        end
    end

    assign o_last = (r_cnt == '0);

endmodule

// File: rtl/ac_sequencer.sv
// Owns AC and sequences the ALU: one command at a time, cmd_cnt+1 EXEC cycles, then a done pulse.
// Latency accept->done is 2+n cycles; cmd_ready is low from accept until the cycle after done.
module ac_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [3:0]       i_cmd_op,
    input  logic [WIDTH-1:0] i_cmd_data,
    input  logic [CNT_W-1:0] i_cmd_cnt,
    output logic [3:0]       o_alus,
    output logic [WIDTH-1:0] o_bus_n,
    input  logic [WIDTH-1:0] i_alu_dout,
    output logic [WIDTH-1:0] o_ac_n,
    output logic             o_zero,
    output logic             o_done,
    output logic             o_err
);

    seq_state_t       r_state;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_ac;
    logic [3:0]       r_alus;
    logic [WIDTH-1:0] r_bus;
    logic             r_ready;
    logic             r_done;
    logic             r_err;

    logic             w_accept;
    logic             w_dec;
    logic             w_last;
    logic [CNT_W-1:0] w_load_val;

    assign w_accept   = r_ready && i_cmd_valid;
    assign w_dec      = (r_state == ST_EXEC);
    assign w_load_val = op_uses_alu(i_cmd_op) ? i_cmd_cnt : '0;

    rep_counter #(
        .CNT_W(CNT_W)
    ) u_rep_counter (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_accept),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_last     (w_last)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_op    <= OP_CLAC;
            r_data  <= '0;
            r_ac    <= '0;
            r_alus  <= ALUS_IDLE;
            r_bus   <= '0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op    <= i_cmd_op;
                        r_data  <= i_cmd_data;
                        // select and operand are registered here so EXEC sees them glitch-free
                        r_alus  <= op_uses_alu(i_cmd_op) ? i_cmd_op : ALUS_IDLE;
                        r_bus   <= i_cmd_data;
                        r_ready <= 1'b0;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (r_op == OP_LDAC) begin
                        r_ac <= r_data;
                    end else if (op_legal(r_op)) begin
                        r_ac <= i_alu_dout;
                    end
                    if (w_last) begin
                        r_alus  <= ALUS_IDLE;
                        r_bus   <= '0;
                        r_done  <= 1'b1;
                        r_err   <= !op_legal(r_op);
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_alus  <= ALUS_IDLE;
                    r_bus   <= '0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready = r_ready;
    assign o_alus      = r_alus;
    assign o_bus_n     = r_bus;
    assign o_ac_n      = r_ac;
    assign o_zero      = (r_ac == '0);
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule

// File: tb/tb_ac_sequencer.sv
// Bench for ac_sequencer: behavioural ALU plus a command-level AC model, directed and random commands.
module tb_ac_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_data;
    logic [3:0] cmd_cnt;
    logic [3:0] alus;
    logic [7:0] bus_n;
    logic [7:0] alu_dout;
    logic [7:0] ac_n;
    logic       zero;
    logic       done;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] m_ac;

    always #5 clk = ~clk;

    ac_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_op    (cmd_op),
        .i_cmd_data  (cmd_data),
        .i_cmd_cnt   (cmd_cnt),
        .o_alus      (alus),
        .o_bus_n     (bus_n),
        .i_alu_dout  (alu_dout),
        .o_ac_n      (ac_n),
        .o_zero      (zero),
        .o_done      (done),
        .o_err       (err)
    );

    // ALU stand-in; undefined selects return junk so any stray AC write shows up
    always_comb begin
        case (alus)
            4'd0:    alu_dout = 8'h00;
            4'd1:    alu_dout = ac_n + bus_n;
            4'd2:    alu_dout = ac_n - bus_n;
            4'd3:    alu_dout = ac_n + 8'd1;
            4'd4:    alu_dout = ac_n & bus_n;
            4'd5:    alu_dout = ac_n | bus_n;
            4'd6:    alu_dout = ~ac_n;
            4'd7:    alu_dout = ac_n ^ bus_n;
            default: alu_dout = 8'hA5;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // AC after one execution of op: the architectural rule, independent of ALU select timing
    function automatic logic [7:0] ac_after(input logic [3:0] op, input logic [7:0] ac, input logic [7:0] d);
        logic [7:0] r;
        case (op)
            4'd0: r = 8'h00;
            4'd1: r = ac + d;
            4'd2: r = ac - d;
            4'd3: r = ac + 8'd1;
            4'd4: r = ac & d;
            4'd5: r = ac | d;
            4'd6: r = ~ac;
            4'd7: r = ac ^ d;
            4'd8: r = d;
            default: r = ac;
        endcase
        return r;
    endfunction

    // Called at a negedge; leaves cmd_valid high at the negedge where cmd_ready has returned
    task automatic run_cmd(input logic [3:0] op, input logic [7:0] d, input logic [3:0] c);
        int budget;
        int passes;
        logic [3:0] exp_alus;
        cmd_op    = op;
        cmd_data  = d;
        cmd_cnt   = c;
        cmd_valid = 1'b1;
        budget = 0;
        while (!cmd_ready && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        check("accept_wait", (budget < 40), 1);
        passes   = (op < 4'd8) ? int'(c) + 1 : 1;
        exp_alus = (op < 4'd8) ? op : 4'hF;
        @(negedge clk);
        for (int k = 0; k < passes; k++) begin
            check("exec_ready", cmd_ready, 0);
            check("exec_alus", alus, exp_alus);
            check("exec_bus", bus_n, d);
            check("exec_done", done, 0);
            check("exec_ac", ac_n, m_ac);
            m_ac = ac_after(op, m_ac, d);
            @(negedge clk);
        end
        check("done_pulse", done, 1);
        check("done_err", err, (op > 4'd8));
        check("done_ready", cmd_ready, 0);
        check("done_ac", ac_n, m_ac);
        check("done_zero", zero, (m_ac == 8'h00));
        check("done_alus", alus, 4'hF);
        check("done_bus", bus_n, 0);
        @(negedge clk);
        check("ready_back", cmd_ready, 1);
        check("post_done", done, 0);
        check("post_err", err, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [3:0] op;
        logic [3:0] c;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 4'd0;
        cmd_data = 8'd0;
        cmd_cnt = 4'd0;
        m_ac = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ac", ac_n, 0);
        check("rst_zero", zero, 1);
        check("rst_alus", alus, 4'hF);
        check("rst_bus", bus_n, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", cmd_ready, 1);

        // repeat ADD, back-to-back with valid held high
        run_cmd(4'd8, 8'h05, 4'd0);
        run_cmd(4'd1, 8'h03, 4'd2);
        check("add_ac", ac_n, 8'h0E);
        check("add_zero", zero, 0);
        // LDAC ignores its count, then CLAC
        run_cmd(4'd8, 8'h7F, 4'd9);
        check("ldac_ac", ac_n, 8'h7F);
        run_cmd(4'd0, 8'h55, 4'd0);
        check("clac_zero", zero, 1);
        // wrap cases
        run_cmd(4'd8, 8'h02, 4'd0);
        run_cmd(4'd2, 8'h05, 4'd0);
        check("sub_wrap", ac_n, 8'hFD);
        run_cmd(4'd8, 8'hFF, 4'd0);
        run_cmd(4'd3, 8'h00, 4'd0);
        check("inac_wrap", ac_n, 8'h00);
        check("inac_zero", zero, 1);
        // illegal op leaves AC alone
        run_cmd(4'd8, 8'h3C, 4'd0);
        run_cmd(4'hA, 8'h11, 4'd3);
        check("illegal_ac", ac_n, 8'h3C);
        // all-ones count gives exactly 16 passes
        run_cmd(4'd8, 8'h00, 4'd0);
        run_cmd(4'd3, 8'h00, 4'hF);
        check("cnt_max", ac_n, 8'h10);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("idle_ready", cmd_ready, 1);
        check("idle_alus", alus, 4'hF);

        // reset beats a same-cycle accept
        cmd_op = 4'd1;
        cmd_data = 8'h22;
        cmd_cnt = 4'd1;
        cmd_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cmd_valid = 1'b0;
        m_ac = 8'h00;
        check("rst_accept_alus", alus, 4'hF);
        check("rst_accept_ready", cmd_ready, 1);
        check("rst_accept_ac", ac_n, 0);
        @(negedge clk);
        check("rst_accept_idle", alus, 4'hF);

        // reset during the second EXEC cycle of a 6-pass ADD
        run_cmd(4'd8, 8'h44, 4'd0);
        cmd_op = 4'd1;
        cmd_data = 8'h01;
        cmd_cnt = 4'd5;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("midop_exec", alus, 4'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_ac = 8'h00;
        check("midop_ac", ac_n, 0);
        check("midop_zero", zero, 1);
        check("midop_alus", alus, 4'hF);
        check("midop_bus", bus_n, 0);
        check("midop_done", done, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("midop_no_done", done, 0);
            check("midop_ready", cmd_ready, 1);
        end

        // random commands with occasional idle gaps
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            op = (r < 2) ? 4'd8 : 4'($urandom_range(0, 15));
            c = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            run_cmd(op, 8'($urandom), c);
            if ($urandom_range(0, 3) == 0) begin
                cmd_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    check("gap_ready", cmd_ready, 1);
                    check("gap_alus", alus, 4'hF);
                    check("gap_ac", ac_n, m_ac);
                end
            end
        end
        cmd_valid = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
